// File: rtl/exu_cal_arb_pkg.sv
// exu_cal_arb_pkg: shared types and constants for the EX calc-unit arbiter.
// Exposes the CAL bundle field positions as typed localparams and a helper that
// packs an operation into a bundle.
`include "cirno9_define.v"

package exu_cal_arb_pkg;

  localparam int unsigned CalOpbW    = `CIRNO_CAL_OPB_SIZE;
  localparam int unsigned CalTagW    = `CIRNO_CAL_ARB_TAG_W;
  localparam int unsigned CalResW    = 32;

  localparam int unsigned CalOpn2Lsb = `CIRNO_CAL_OPN2_LSB;
  localparam int unsigned CalOpn1Lsb = `CIRNO_CAL_OPN1_LSB;
  localparam int unsigned CalAddBit  = `CIRNO_CAL_ADD;
  localparam int unsigned CalSubBit  = `CIRNO_CAL_SUB;
  localparam int unsigned CalSllBit  = `CIRNO_CAL_SLL;
  localparam int unsigned CalXorBit  = `CIRNO_CAL_XOR;
  localparam int unsigned CalCmpBit  = `CIRNO_CAL_CMP;

  typedef enum logic [2:0] {
    CalAdd,
    CalSub,
    CalSll,
    CalXor,
    CalCmp
  } cal_op_e;

  function automatic logic [CalOpbW-1:0] cal_pack(input cal_op_e op, input logic [31:0] opn1,
                                                  input logic [31:0] opn2);
    logic [CalOpbW-1:0] opb;
    opb = '0;
    opb[CalOpn1Lsb +: 32] = opn1;
    opb[CalOpn2Lsb +: 32] = opn2;
    case (op)
      CalAdd:  opb[CalAddBit] = 1'b1;
      CalSub:  opb[CalSubBit] = 1'b1;
      CalSll:  opb[CalSllBit] = 1'b1;
      CalXor:  opb[CalXorBit] = 1'b1;
      CalCmp:  opb[CalCmpBit] = 1'b1;
      default: opb = '0;
    endcase
    return opb;
  endfunction

endpackage

// File: rtl/exu_cal_arb_if.sv
// exu_cal_arb_if: one requester's channel into the calc arbiter.
//   req_val/req_rdy/req_opb/req_tag : operation handshake (requester -> arbiter)
//   rsp_val/rsp_rdy/rsp_res/rsp_tag : result handshake (arbiter -> requester)
// master = requester side, slave = arbiter side.
interface exu_cal_arb_if #(
  parameter int unsigned OPB_W = exu_cal_arb_pkg::CalOpbW,
  parameter int unsigned TAG_W = exu_cal_arb_pkg::CalTagW
);

  logic             req_val;
  logic             req_rdy;
  logic [OPB_W-1:0] req_opb;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_val;
  logic             rsp_rdy;
  logic [31:0]      rsp_res;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_val, req_opb, req_tag, rsp_rdy,
    input  req_rdy, rsp_val, rsp_res, rsp_tag
  );

  modport slave (
    input  req_val, req_opb, req_tag, rsp_rdy,
    output req_rdy, rsp_val, rsp_res, rsp_tag
  );

endinterface

// File: rtl/cirno9_define.v
// cirno9 shared defines: CAL operation bundle field positions and arbiter tag width.
// Bundle layout, LSB first: opn2[31:0], opn1[31:0], then one-hot op bits
// (add, sub, sll, xor, cmp).
`ifndef CIRNO9_DEFINE_V
`define CIRNO9_DEFINE_V

`define CIRNO_CAL_OPN2_LSB   0
`define CIRNO_CAL_OPN2_MSB   31
`define CIRNO_CAL_OPN1_LSB   32
`define CIRNO_CAL_OPN1_MSB   63
`define CIRNO_CAL_ADD        64
`define CIRNO_CAL_SUB        65
`define CIRNO_CAL_SLL        66
`define CIRNO_CAL_XOR        67
`define CIRNO_CAL_CMP        68
`define CIRNO_CAL_OPB_SIZE   69

`define CIRNO_CAL_ARB_TAG_W  4

`endif

// File: rtl/exu_cal_arb_rr2.sv
// exu_cal_arb_rr2: 2-way grant with round-robin priority pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request vector
//   advance    : a grant was consumed this cycle
//   grant      : index of the granted requester (0 when nothing requests)
// With CIRNO_CAL_ARB_FIXPRI_EN defined, requester 0 always wins a conflict and the
// pointer is not built.
module exu_cal_arb_rr2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant
);

`ifdef CIRNO_CAL_ARB_FIXPRI_EN

  assign grant = req[1] & ~req[0];

  logic unused_fixpri;
  assign unused_fixpri = ^{clk, rst_n, advance};

`else

  logic rr_ptr_q;
  logic rr_ptr_d;

  always_comb begin
    grant    = (req == 2'b11) ? rr_ptr_q : req[1];
    rr_ptr_d = rr_ptr_q;
    // The pointer only moves when a real conflict was resolved.
    if (advance && (req == 2'b11)) begin
      rr_ptr_d = ~grant;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

`endif

endmodule

// File: rtl/exu_cal_arb.sv
// exu_cal_arb: two-requester arbiter and one-entry result slot in front of the shared
// EX integer calc unit.
//   clk, rst_n     : clock, asynchronous active-low reset
//   ch0, ch1       : requester channels (ch0 = EX issue, ch1 = branch-compare/AGU)
//   cal_val/cal_rdy: operation handoff to the calc unit
//   cal_opb        : granted bundle, all zero when nobody requests
//   cal_res        : combinational calc result, captured on accept
// Optional build macro CIRNO_CAL_ARB_FIXPRI_EN: requester 0 wins every conflict.
module exu_cal_arb
  import exu_cal_arb_pkg::*;
#(
  parameter int unsigned OPB_W = CalOpbW,
  parameter int unsigned TAG_W = CalTagW
) (
  input  logic             clk,
  input  logic             rst_n,
  exu_cal_arb_if.slave     ch0,
  exu_cal_arb_if.slave     ch1,
  output logic             cal_val,
  input  logic             cal_rdy,
  output logic [OPB_W-1:0] cal_opb,
  input  logic [31:0]      cal_res
);

  logic             slot_full_q, slot_full_d;
  logic             owner_q, owner_d;
  logic [31:0]      res_q, res_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic [1:0] req_vec;
  logic       grant;
  logic       drain;
  logic       slot_free;
  logic       accept;

  assign req_vec = {ch1.req_val, ch0.req_val};

  exu_cal_arb_rr2 u_rr2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_vec),
    .advance (accept),
    .grant   (grant)
  );

  always_comb begin
    drain     = slot_full_q & (owner_q ? ch1.rsp_rdy : ch0.rsp_rdy);
    // A draining slot can be refilled in the same cycle: 1 op/cycle streaming.
    slot_free = ~slot_full_q | drain;
    // rst_n gate keeps rdy/cal_val low while reset is held with requests pending.
    accept    = rst_n & slot_free & cal_rdy & (|req_vec);

    slot_full_d = slot_full_q;
    owner_d     = owner_q;
    res_d       = res_q;
    tag_d       = tag_q;
    if (accept) begin
      slot_full_d = 1'b1;
      owner_d     = grant;
      res_d       = cal_res;
      tag_d       = grant ? ch1.req_tag : ch0.req_tag;
    end else if (drain) begin
      slot_full_d = 1'b0;
    end
  end

  always_comb begin
    cal_opb = '0;
    if (|req_vec) begin
      cal_opb = grant ? ch1.req_opb : ch0.req_opb;
    end
  end

  assign cal_val     = accept;
  assign ch0.req_rdy = accept & ~grant;
  assign ch1.req_rdy = accept & grant;

  // Result/tag stay visible on the owner's port after a drain; only val drops.
  assign ch0.rsp_val = slot_full_q & ~owner_q;
  assign ch1.rsp_val = slot_full_q & owner_q;
  assign ch0.rsp_res = owner_q ? '0 : res_q;
  assign ch1.rsp_res = owner_q ? res_q : '0;
  assign ch0.rsp_tag = owner_q ? '0 : tag_q;
  assign ch1.rsp_tag = owner_q ? tag_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_full_q <= 1'b0;
      owner_q     <= 1'b0;
      res_q       <= '0;
      tag_q       <= '0;
    end else begin
      slot_full_q <= slot_full_d;
      owner_q     <= owner_d;
      res_q       <= res_d;
      tag_q       <= tag_d;
    end
  end

endmodule

// File: tb/tb_exu_cal_arb.sv
// tb_exu_cal_arb: directed scenarios followed by randomized traffic for exu_cal_arb,
// checked against a transaction-level reference model (pending result queue plus
// priority flag). The calc unit is modelled here from the bundle one-hots.
module tb_exu_cal_arb;
  import exu_cal_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic               cal_val;
  logic               cal_rdy;
  logic [CalOpbW-1:0] cal_opb;
  logic [31:0]        cal_res;

  exu_cal_arb_if ch0_if ();
  exu_cal_arb_if ch1_if ();

  exu_cal_arb #(
    .OPB_W (CalOpbW),
    .TAG_W (CalTagW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ch0     (ch0_if),
    .ch1     (ch1_if),
    .cal_val (cal_val),
    .cal_rdy (cal_rdy),
    .cal_opb (cal_opb),
    .cal_res (cal_res)
  );

  function automatic logic [31:0] calc_unit(input logic [CalOpbW-1:0] b);
    logic [31:0] x, y;
    x = b[CalOpn1Lsb +: 32];
    y = b[CalOpn2Lsb +: 32];
    if (b[CalAddBit]) return x + y;
    if (b[CalSubBit]) return x - y;
    if (b[CalSllBit]) return x << y[4:0];
    if (b[CalXorBit]) return x ^ y;
    if (b[CalCmpBit]) return {31'd0, x < y};
    return 32'd0;
  endfunction

  always_comb cal_res = calc_unit(cal_opb);

  function automatic logic [31:0] ref_result(input cal_op_e op, input logic [31:0] a,
                                             input logic [31:0] b);
    case (op)
      CalAdd:  return a + b;
      CalSub:  return a - b;
      CalSll:  return a << (b % 32);
      CalXor:  return a ^ b;
      CalCmp:  return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  typedef struct packed {
    logic               owner;
    logic [31:0]        res;
    logic [CalTagW-1:0] tag;
  } rsp_t;

  // Stimulus state.
  bit                 rq_val[2];
  cal_op_e            rq_op[2];
  logic [31:0]        rq_a[2];
  logic [31:0]        rq_b[2];
  logic [CalTagW-1:0] rq_tag[2];
  bit                 rsp_rdy_m[2];
  bit                 cal_rdy_m;

  // Reference model state.
  rsp_t slot_q[$];
  rsp_t shown;
  bit   prio;
  bit   e_acc, e_win, e_drain;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input bit v, input cal_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [CalTagW-1:0] tag);
    rq_val[i] = v;
    rq_op[i]  = op;
    rq_a[i]   = a;
    rq_b[i]   = b;
    rq_tag[i] = tag;
  endtask

  task automatic model_reset();
    slot_q.delete();
    shown = '0;
    prio  = 1'b0;
  endtask

  task automatic drive();
    ch0_if.req_val = rq_val[0];
    ch0_if.req_opb = cal_pack(rq_op[0], rq_a[0], rq_b[0]);
    ch0_if.req_tag = rq_tag[0];
    ch0_if.rsp_rdy = rsp_rdy_m[0];
    ch1_if.req_val = rq_val[1];
    ch1_if.req_opb = cal_pack(rq_op[1], rq_a[1], rq_b[1]);
    ch1_if.req_tag = rq_tag[1];
    ch1_if.rsp_rdy = rsp_rdy_m[1];
    cal_rdy        = cal_rdy_m;
  endtask

  // Apply inputs just after a negedge, then compare every output with the model.
  task automatic settle();
    bit any, both, full, pick, own1;
    drive();
    #1;
    any  = rq_val[0] || rq_val[1];
    both = rq_val[0] && rq_val[1];
    full = slot_q.size() != 0;
    own1 = 1'b0;
    e_drain = 1'b0;
    if (full) begin
      own1    = slot_q[0].owner;
      e_drain = rsp_rdy_m[slot_q[0].owner];
    end
`ifdef CIRNO_CAL_ARB_FIXPRI_EN
    pick = 1'b0;
`else
    pick = prio;
`endif
    e_win = both ? pick : rq_val[1];
    e_acc = rst_n && (!full || e_drain) && cal_rdy_m && any;

    chk("req0_rdy", ch0_if.req_rdy, e_acc && !e_win);
    chk("req1_rdy", ch1_if.req_rdy, e_acc && e_win);
    chk("cal_val", cal_val, e_acc);
    chk("cal_opb", cal_opb, any ? cal_pack(rq_op[e_win], rq_a[e_win], rq_b[e_win]) : '0);
    chk("rsp0_val", ch0_if.rsp_val, full && !own1);
    chk("rsp1_val", ch1_if.rsp_val, full && own1);
    chk("rsp0_res", ch0_if.rsp_res, shown.owner ? 32'd0 : shown.res);
    chk("rsp1_res", ch1_if.rsp_res, shown.owner ? shown.res : 32'd0);
    chk("rsp0_tag", ch0_if.rsp_tag, shown.owner ? '0 : shown.tag);
    chk("rsp1_tag", ch1_if.rsp_tag, shown.owner ? shown.tag : '0);
  endtask

  task automatic tick();
    rsp_t r;
    @(posedge clk);
    if (rst_n) begin
      if (e_acc) begin
        r.owner = e_win;
        r.res   = ref_result(rq_op[e_win], rq_a[e_win], rq_b[e_win]);
        r.tag   = rq_tag[e_win];
        slot_q.delete();
        slot_q.push_back(r);
        shown = r;
        if (rq_val[0] && rq_val[1]) prio = !e_win;
      end else if (e_drain) begin
        void'(slot_q.pop_front());
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bit taken;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_req(i, 1'b0, CalAdd, 32'd0, 32'd0, '0);
      rsp_rdy_m[i] = 1'b1;
    end
    cal_rdy_m = 1'b1;
    model_reset();

    // Reset held with a request pending: nothing may be accepted.
    set_req(0, 1'b1, CalAdd, 32'd5, 32'd3, 4'd2);
    @(negedge clk);
    repeat (2) begin
      settle();
      chk("rst_req0_rdy", ch0_if.req_rdy, 1'b0);
      chk("rst_cal_val", cal_val, 1'b0);
      chk("rst_rsp0_val", ch0_if.rsp_val, 1'b0);
      tick();
    end

    // Release: the pending ADD is taken on the first edge.
    rst_n = 1'b1;
    settle();
    chk("rel_req0_rdy", ch0_if.req_rdy, 1'b1);
    tick();
    rq_val[0] = 1'b0;
    settle();
    chk("add_val", ch0_if.rsp_val, 1'b1);
    chk("add_res", ch0_if.rsp_res, 32'd8);
    chk("add_tag", ch0_if.rsp_tag, 32'd2);
    chk("add_rsp1_val", ch1_if.rsp_val, 1'b0);
    tick();

    // Conflict.
    set_req(0, 1'b1, CalSub, 32'd10, 32'd4, 4'd1);
    set_req(1, 1'b1, CalXor, 32'hF0, 32'hFF, 4'd7);
    settle();
    chk("conf1_req0_rdy", ch0_if.req_rdy, 1'b1);
    tick();
    settle();
    chk("conf_sub_res", ch0_if.rsp_res, 32'd6);
    chk("conf_sub_tag", ch0_if.rsp_tag, 32'd1);
`ifdef CIRNO_CAL_ARB_FIXPRI_EN
    chk("conf2_req0_rdy", ch0_if.req_rdy, 1'b1);
`else
    chk("conf2_req1_rdy", ch1_if.req_rdy, 1'b1);
`endif
    tick();
    rq_val[0] = 1'b0;
    rq_val[1] = 1'b0;
    settle();
`ifdef CIRNO_CAL_ARB_FIXPRI_EN
    chk("conf_sub2_res", ch0_if.rsp_res, 32'd6);
`else
    chk("conf_xor_val", ch1_if.rsp_val, 1'b1);
    chk("conf_xor_res", ch1_if.rsp_res, 32'h0F);
    chk("conf_xor_tag", ch1_if.rsp_tag, 32'd7);
`endif
    tick();
    settle();
    tick();

    // Back-pressure on requester 1 with requester 0 waiting.
    rsp_rdy_m[1] = 1'b0;
    set_req(1, 1'b1, CalCmp, 32'd3, 32'd5, 4'd3);
    settle();
    chk("bp_req1_rdy", ch1_if.req_rdy, 1'b1);
    tick();
    rq_val[1] = 1'b0;
    set_req(0, 1'b1, CalAdd, 32'd1, 32'd1, 4'd4);
    repeat (3) begin
      settle();
      chk("bp_hold_val", ch1_if.rsp_val, 1'b1);
      chk("bp_hold_res", ch1_if.rsp_res, 32'd1);
      chk("bp_req0_rdy", ch0_if.req_rdy, 1'b0);
      tick();
    end
    rsp_rdy_m[1] = 1'b1;
    settle();
    chk("bp_release_rdy", ch0_if.req_rdy, 1'b1);
    tick();
    rq_val[0] = 1'b0;
    settle();
    chk("bp_add_res", ch0_if.rsp_res, 32'd2);
    chk("bp_add_tag", ch0_if.rsp_tag, 32'd4);
    chk("bp_rsp1_gone", ch1_if.rsp_val, 1'b0);
    tick();

    // Back-to-back stream.
    for (int k = 0; k < 8; k++) begin
      set_req(0, 1'b1, CalSll, 32'd1, k, k[CalTagW-1:0]);
      settle();
      chk("b2b_rdy", ch0_if.req_rdy, 1'b1);
      if (k > 0) begin
        chk("b2b_val", ch0_if.rsp_val, 1'b1);
        chk("b2b_res", ch0_if.rsp_res, 32'd1 << (k - 1));
        chk("b2b_tag", ch0_if.rsp_tag, k - 1);
      end
      tick();
    end
    rq_val[0] = 1'b0;
    settle();
    chk("b2b_last_res", ch0_if.rsp_res, 32'd128);
    chk("b2b_last_tag", ch0_if.rsp_tag, 32'd7);
    tick();

    // Reset while the slot is full and stalled.
    rsp_rdy_m[0] = 1'b0;
    set_req(0, 1'b1, CalXor, 32'h1234, 32'h00FF, 4'd9);
    settle();
    tick();
    rq_val[0] = 1'b0;
    settle();
    chk("mid_full_val", ch0_if.rsp_val, 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_val", ch0_if.rsp_val, 1'b0);
    chk("mid_rst_res", ch0_if.rsp_res, 32'd0);
    chk("mid_rst_tag", ch0_if.rsp_tag, 32'd0);
    tick();
    settle();
    tick();
    rst_n = 1'b1;
    rsp_rdy_m[0] = 1'b1;
    settle();
    chk("post_rst_res", ch0_if.rsp_res, 32'd0);
    tick();

    // Randomized traffic obeying the requester rules.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        taken = e_acc && (e_win == (i == 1));
        if (rq_val[i] && !taken) begin
          if ($urandom_range(0, 9) == 0) rq_val[i] = 1'b0;
        end else begin
          rq_val[i] = ($urandom_range(0, 9) < 6);
          rq_op[i]  = cal_op_e'($urandom_range(0, 4));
          rq_a[i]   = $urandom;
          rq_b[i]   = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 40);
          rq_tag[i] = CalTagW'($urandom_range(0, 15));
        end
        rsp_rdy_m[i] = ($urandom_range(0, 9) < 7);
      end
      cal_rdy_m = ($urandom_range(0, 9) < 8);
      settle();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
